t_vga_v1_onchip_mem_arbiter: RTL and testbench

//  Shares the single-port 5120x32 on-chip frame/feature RAM between two Avalon-MM masters.
//  m0 = VGA line fetcher (read-only, bursts); m1 = host/tracker (single-beat read/write).

---
 rtl/t_vga_v1_arb_pkg.sv | 40 ++++
 rtl/t_vga_v1_arb_burst_ctr.sv | 51 +++++
 rtl/t_vga_v1_onchip_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_t_vga_v1_onchip_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/t_vga_v1_arb_pkg.sv
// Shared sizes, types and helpers for the VGA on-chip memory arbiter.
// Covers both builds, with and without VGA_ARB_STARVE_GUARD_EN.
package t_vga_v1_arb_pkg;

    localparam int ADDR_W       = 13;
    localparam int DATA_W       = 32;
    localparam int BE_W         = DATA_W / 8;
    localparam int MEM_DEPTH    = 5120;
    localparam int MAX_BURST    = 16;
    localparam int BURST_W      = $clog2(MAX_BURST) + 1;
    localparam int STARVE_LIMIT = 8;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;
    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   oob;
    } ret_tag_t;

    function automatic logic is_oob(input logic [ADDR_W-1:0] addr);
        return (addr >= ADDR_W'(MEM_DEPTH));
    endfunction

    // Zero-length requests count as one beat; oversize requests are clamped.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] cnt);
        logic [BURST_W-1:0] r;
        if (cnt == '0) begin
            r = BURST_W'(1);
        end else if (cnt > BURST_W'(MAX_BURST)) begin
            r = BURST_W'(MAX_BURST);
        end else begin
            r = cnt;
        end
        return r;
    endfunction

endpackage

// File: rtl/t_vga_v1_arb_burst_ctr.sv
// Burst address/beat tracker for m0 line fetches: holds the next beat address and the
// number of beats still to issue once the first beat has gone out from ARB_IDLE.
module t_vga_v1_arb_burst_ctr
    import t_vga_v1_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    input  logic [BURST_W-1:0] count_i,
    input  logic               step_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               last_o,
    output logic               oob_o
);

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] left_q, left_d;

    // Next-state: the first beat is issued at load time, so load start+1 / count-1.
    always_comb begin
        addr_d = addr_q;
        left_d = left_q;
        if (load_i) begin
            addr_d = start_addr_i + ADDR_W'(1);
            left_d = count_i - BURST_W'(1);
        end else if (step_i) begin
            addr_d = addr_q + ADDR_W'(1);
            left_d = left_q - BURST_W'(1);
        end else begin
            addr_d = addr_q;
            left_d = left_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            left_q <= '0;
        end else begin
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (left_q == BURST_W'(1));
    assign oob_o  = is_oob(addr_q);

endmodule

// File: rtl/t_vga_v1_onchip_mem_arbiter.sv
// Shares the single-port 5120x32 frame/feature RAM between the VGA line fetcher (m0, bursts)
// and the host/tracker (m1). Define VGA_ARB_STARVE_GUARD_EN to bound how long m1 can wait.
module t_vga_v1_onchip_mem_arbiter
    import t_vga_v1_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic               m0_read,
    input  logic [BURST_W-1:0] m0_burstcount,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [BE_W-1:0]    m1_byteenable,
    input  logic [DATA_W-1:0]  m1_writedata,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [BE_W-1:0]    mem_byteenable,
    output logic [DATA_W-1:0]  mem_writedata,
    input  logic [DATA_W-1:0]  mem_readdata
);

    arb_state_t         state_q, state_d;
    ret_tag_t           tag_q, tag_d;
    logic               m1_req_s, grant_m1_s, starve_force_s;
    logic               load_s, step_s, burst_last_s, burst_oob_s;
    logic [ADDR_W-1:0]  burst_addr_s;
    logic [BURST_W-1:0] eff_cnt_s;

    assign m1_req_s   = m1_read | m1_write;
    assign grant_m1_s = m1_req_s & (~m0_read | starve_force_s);
    assign eff_cnt_s  = eff_burst(m0_burstcount);

    t_vga_v1_arb_burst_ctr u_burst_ctr (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (load_s),
        .start_addr_i (m0_address),
        .count_i      (eff_cnt_s),
        .step_i       (step_s),
        .addr_o       (burst_addr_s),
        .last_o       (burst_last_s),
        .oob_o        (burst_oob_s)
    );

    // Grant, RAM drive and next state; outputs held quiet while reset is asserted.
    always_comb begin
        state_d        = state_q;
        tag_d          = '0;
        load_s         = 1'b0;
        step_s         = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (!reset_n) begin
            state_d = ARB_IDLE;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_m1_s) begin
                        m1_waitrequest = 1'b0;
                        mem_address    = m1_address;
                        mem_chipselect = ~is_oob(m1_address);
                        if (m1_write) begin
                            mem_write      = ~is_oob(m1_address);
                            mem_byteenable = m1_byteenable;
                            mem_writedata  = m1_writedata;
                        end else begin
                            mem_byteenable = '1;
                            tag_d = '{valid: 1'b1, owner: OWN_M1, oob: is_oob(m1_address)};
                        end
                    end else if (m0_read) begin
                        m0_waitrequest = 1'b0;
                        mem_address    = m0_address;
                        mem_chipselect = ~is_oob(m0_address);
                        mem_byteenable = '1;
                        tag_d = '{valid: 1'b1, owner: OWN_M0, oob: is_oob(m0_address)};
                        if (eff_cnt_s > BURST_W'(1)) begin
                            load_s  = 1'b1;
                            state_d = ARB_BURST;
                        end else begin
                            state_d = ARB_IDLE;
                        end
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
                ARB_BURST: begin
                    step_s         = 1'b1;
                    mem_address    = burst_addr_s;
                    mem_chipselect = ~burst_oob_s;
                    mem_byteenable = '1;
                    tag_d = '{valid: 1'b1, owner: OWN_M0, oob: burst_oob_s};
                    if (burst_last_s) begin
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_BURST;
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    // State and read-return tag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

`ifdef VGA_ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_q, starve_d;

    // Count cycles m1 is held off (bursts included); saturate at the limit, clear on acceptance.
    always_comb begin
        starve_d = starve_q;
        if (m1_req_s && !m1_waitrequest) begin
            starve_d = '0;
        end else if (m1_req_s && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign starve_force_s = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
    assign starve_force_s = 1'b0;
`endif

    assign m0_readdatavalid = tag_q.valid & (tag_q.owner == OWN_M0);
    assign m1_readdatavalid = tag_q.valid & (tag_q.owner == OWN_M1);
    assign m0_readdata      = tag_q.oob ? '0 : mem_readdata;
    assign m1_readdata      = tag_q.oob ? '0 : mem_readdata;

endmodule

// File: tb/tb_t_vga_v1_onchip_mem_arbiter.sv
// Self-checking bench for t_vga_v1_onchip_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration and memory contents.
module tb_t_vga_v1_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] m0_address = 13'd0;
    logic        m0_read = 1'b0;
    logic [4:0]  m0_burstcount = 5'd0;
    logic        m0_waitrequest, m0_readdatavalid;
    logic [31:0] m0_readdata;
    logic [12:0] m1_address = 13'd0;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [3:0]  m1_byteenable = 4'd0;
    logic [31:0] m1_writedata = 32'd0;
    logic        m1_waitrequest, m1_readdatavalid;
    logic [31:0] m1_readdata;
    logic [12:0] mem_address;
    logic        mem_chipselect, mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [0:5119];
    bit   [31:0] ram_x   [0:5119];

    t_vga_v1_onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_burstcount(m0_burstcount),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        return 32'(a) * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM contents are stored XORed with their initial value so the array needs no init writes.
    always @(posedge clk) begin
        if (mem_chipselect && (mem_address < 13'd5120)) begin
            if (mem_write)
                ram_x[mem_address] <= merge(ram_x[mem_address] ^ init_word(int'(mem_address)),
                                            mem_writedata, mem_byteenable) ^ init_word(int'(mem_address));
            else
                mem_readdata <= ram_x[mem_address] ^ init_word(int'(mem_address));
        end
    end

    task automatic drive(input logic r0, input logic [12:0] a0, input logic [4:0] bc,
                         input logic r1, input logic w1, input logic [12:0] a1,
                         input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        m0_read = r0; m0_address = a0; m0_burstcount = bc;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be; m1_writedata = wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 13'd0, 5'd0, 1'b0, 1'b0, 13'd0, 4'd0, 32'd0);
    endtask

    task automatic test_reset();
        m0_read = 1'b1; m0_address = 13'h010; m0_burstcount = 5'd4;
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 13'h040; m1_byteenable = 4'hF; m1_writedata = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin n_errors++; $display("FAIL reset_wait: got %b exp 11", {m0_waitrequest, m1_waitrequest}); end
        n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_errors++; $display("FAIL reset_valid: got %b exp 00", {m0_readdatavalid, m1_readdatavalid}); end
        n_checks++; if ({mem_chipselect, mem_write} !== 2'b00) begin n_errors++; $display("FAIL reset_cs_we: got %b exp 00", {mem_chipselect, mem_write}); end
        n_checks++; if ({mem_address, mem_byteenable, mem_writedata} !== 49'd0) begin n_errors++; $display("FAIL reset_mem_bus: got addr %h be %h wd %h exp 0", mem_address, mem_byteenable, mem_writedata); end
        idle();
        reset_n = 1'b1;
        idle();
        n_checks++; if ({mem_chipselect, m0_readdatavalid, m1_readdatavalid} !== 3'b000) begin n_errors++; $display("FAIL reset_release_idle: got %b exp 000", {mem_chipselect, m0_readdatavalid, m1_readdatavalid}); end
    endtask

    task automatic test_burst();
        drive(1'b1, 13'h010, 5'd4, 1'b0, 1'b0, 13'd0, 4'd0, 32'd0);
        n_checks++; if (m0_waitrequest !== 1'b0) begin n_errors++; $display("FAIL burst_accept: got wait %b exp 0", m0_waitrequest); end
        n_checks++; if ({mem_chipselect, mem_write, mem_address, mem_byteenable} !== {1'b1, 1'b0, 13'h010, 4'hF}) begin n_errors++; $display("FAIL burst_beat0: got cs %b we %b addr %h be %h exp 1 0 010 f", mem_chipselect, mem_write, mem_address, mem_byteenable); end
        for (int k = 1; k <= 4; k++) begin
            idle();
            if (k < 4) begin
                n_checks++; if (m0_waitrequest !== 1'b1) begin n_errors++; $display("FAIL burst_wait beat %0d: got %b exp 1", k + 1, m0_waitrequest); end
                n_checks++; if ({mem_chipselect, mem_address} !== {1'b1, 13'(16 + k)}) begin n_errors++; $display("FAIL burst_addr beat %0d: got cs %b addr %h exp 1 %h", k + 1, mem_chipselect, mem_address, 13'(16 + k)); end
            end else begin
                n_checks++; if (mem_chipselect !== 1'b0) begin n_errors++; $display("FAIL burst_end_cs: got %b exp 0", mem_chipselect); end
            end
            n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin n_errors++; $display("FAIL burst_valid %0d: got %b exp 10", k, {m0_readdatavalid, m1_readdatavalid}); end
            n_checks++; if (m0_readdata !== ref_mem[16 + k - 1]) begin n_errors++; $display("FAIL burst_data %0d: got %h exp %h", k, m0_readdata, ref_mem[16 + k - 1]); end
        end
        idle();
        n_checks++; if (m0_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL burst_tail_valid: got %b exp 0", m0_readdatavalid); end
    endtask

    task automatic test_write_read();
        logic [31:0] old;
        old = ref_mem[64];
        drive(1'b0, 13'd0, 5'd0, 1'b0, 1'b1, 13'h040, 4'b0011, 32'hDEAD_BEEF);
        n_checks++; if (m1_waitrequest !== 1'b0) begin n_errors++; $display("FAIL wr_accept: got %b exp 0", m1_waitrequest); end
        n_checks++; if ({mem_chipselect, mem_write, mem_byteenable, mem_writedata} !== {1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL wr_bus: got cs %b we %b be %b wd %h", mem_chipselect, mem_write, mem_byteenable, mem_writedata); end
        ref_mem[64] = merge(old, 32'hDEAD_BEEF, 4'b0011);
        drive(1'b0, 13'd0, 5'd0, 1'b1, 1'b0, 13'h040, 4'h0, 32'd0);
        n_checks++; if ({m1_waitrequest, m1_readdatavalid} !== 2'b00) begin n_errors++; $display("FAIL rd_accept_no_wr_valid: got %b exp 00", {m1_waitrequest, m1_readdatavalid}); end
        n_checks++; if ({mem_write, mem_byteenable} !== {1'b0, 4'hF}) begin n_errors++; $display("FAIL rd_be: got we %b be %h exp 0 f", mem_write, mem_byteenable); end
        idle();
        n_checks++; if (m1_readdatavalid !== 1'b1) begin n_errors++; $display("FAIL rd_valid: got %b exp 1", m1_readdatavalid); end
        n_checks++; if (m1_readdata !== {old[31:16], 16'hBEEF}) begin n_errors++; $display("FAIL rd_merge: got %h exp %h", m1_readdata, {old[31:16], 16'hBEEF}); end
    endtask

    task automatic test_contention();
        drive(1'b1, 13'h100, 5'd2, 1'b1, 1'b0, 13'h200, 4'hF, 32'd0);
        n_checks++; if ({m0_waitrequest, m1_waitrequest, mem_address} !== {1'b0, 1'b1, 13'h100}) begin n_errors++; $display("FAIL cont_grant_m0: got w0 %b w1 %b addr %h", m0_waitrequest, m1_waitrequest, mem_address); end
        drive(1'b0, 13'd0, 5'd0, 1'b1, 1'b0, 13'h200, 4'hF, 32'd0);
        n_checks++; if ({m0_waitrequest, m1_waitrequest, mem_address} !== {1'b1, 1'b1, 13'h101}) begin n_errors++; $display("FAIL cont_burst_beat2: got w0 %b w1 %b addr %h", m0_waitrequest, m1_waitrequest, mem_address); end
        n_checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, ref_mem[256]}) begin n_errors++; $display("FAIL cont_m0_data0: got %b %h exp 1 %h", m0_readdatavalid, m0_readdata, ref_mem[256]); end
        drive(1'b0, 13'd0, 5'd0, 1'b1, 1'b0, 13'h200, 4'hF, 32'd0);
        n_checks++; if ({m1_waitrequest, mem_address} !== {1'b0, 13'h200}) begin n_errors++; $display("FAIL cont_grant_m1: got w1 %b addr %h exp 0 200", m1_waitrequest, mem_address); end
        n_checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, ref_mem[257]}) begin n_errors++; $display("FAIL cont_m0_data1: got %b %h exp 1 %h", m0_readdatavalid, m0_readdata, ref_mem[257]); end
        idle();
        n_checks++; if ({m0_readdatavalid, m1_readdatavalid, m1_readdata} !== {2'b01, ref_mem[512]}) begin n_errors++; $display("FAIL cont_m1_data: got %b%b %h exp 01 %h", m0_readdatavalid, m1_readdatavalid, m1_readdata, ref_mem[512]); end
    endtask

    task automatic test_oob();
        drive(1'b0, 13'd0, 5'd0, 1'b1, 1'b0, 13'd5120, 4'hF, 32'd0);
        n_checks++; if ({m1_waitrequest, mem_chipselect} !== 2'b00) begin n_errors++; $display("FAIL oob_m1_rd: got w1 %b cs %b exp 0 0", m1_waitrequest, mem_chipselect); end
        drive(1'b1, 13'd5119, 5'd3, 1'b0, 1'b0, 13'd0, 4'h0, 32'd0);
        n_checks++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL oob_m1_data: got %b %h exp 1 0", m1_readdatavalid, m1_readdata); end
        n_checks++; if ({m0_waitrequest, mem_chipselect, mem_address} !== {1'b0, 1'b1, 13'd5119}) begin n_errors++; $display("FAIL oob_burst_start: got w0 %b cs %b addr %0d", m0_waitrequest, mem_chipselect, mem_address); end
        for (int k = 1; k <= 3; k++) begin
            idle();
            n_checks++; if (mem_chipselect !== 1'b0) begin n_errors++; $display("FAIL oob_burst_cs %0d: got %b exp 0", k, mem_chipselect); end
            n_checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, (k == 1) ? ref_mem[5119] : 32'h0}) begin n_errors++; $display("FAIL oob_burst_data %0d: got %b %h", k, m0_readdatavalid, m0_readdata); end
        end
        drive(1'b0, 13'd0, 5'd0, 1'b0, 1'b1, 13'd5200, 4'hF, 32'h1234_5678);
        n_checks++; if ({m1_waitrequest, mem_chipselect, mem_write} !== 3'b000) begin n_errors++; $display("FAIL oob_wr: got w1 %b cs %b we %b exp 000", m1_waitrequest, mem_chipselect, mem_write); end
        idle();
        n_checks++; if (m1_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL oob_wr_valid: got %b exp 0", m1_readdatavalid); end
    endtask

    task automatic test_starve();
        logic        exp_w1, pv0, pv1;
        logic [31:0] pd;
        logic [12:0] a;
        pv0 = 1'b0; pv1 = 1'b0; pd = 32'd0;
        for (int c = 0; c < 12; c++) begin
            a = 13'($urandom_range(0, 255));
            drive(1'b1, a, 5'd1, 1'b1, 1'b0, 13'h300, 4'hF, 32'd0);
`ifdef VGA_ARB_STARVE_GUARD_EN
            exp_w1 = (c != 8);
`else
            exp_w1 = 1'b1;
`endif
            n_checks++; if ({m0_waitrequest, m1_waitrequest} !== {~exp_w1, exp_w1}) begin n_errors++; $display("FAIL starve_grant c%0d: got w0 %b w1 %b exp %b %b", c, m0_waitrequest, m1_waitrequest, ~exp_w1, exp_w1); end
            n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== {pv0, pv1}) begin n_errors++; $display("FAIL starve_valid c%0d: got %b%b exp %b%b", c, m0_readdatavalid, m1_readdatavalid, pv0, pv1); end
            if (pv0 || pv1) begin
                n_checks++; if ((pv1 ? m1_readdata : m0_readdata) !== pd) begin n_errors++; $display("FAIL starve_data c%0d: got %h exp %h", c, pv1 ? m1_readdata : m0_readdata, pd); end
            end
            pv0 = exp_w1; pv1 = ~exp_w1; pd = exp_w1 ? ref_mem[a] : ref_mem[768];
        end
        drive(1'b0, 13'd0, 5'd0, 1'b1, 1'b0, 13'h300, 4'hF, 32'd0);
        n_checks++; if (m1_waitrequest !== 1'b0) begin n_errors++; $display("FAIL starve_drain_grant: got %b exp 0", m1_waitrequest); end
        idle();
        n_checks++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, ref_mem[768]}) begin n_errors++; $display("FAIL starve_drain_data: got %b %h exp 1 %h", m1_readdatavalid, m1_readdata, ref_mem[768]); end
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b1, 13'h020, 5'd16, 1'b0, 1'b0, 13'd0, 4'h0, 32'd0);
        idle();
        n_checks++; if ({mem_address, m0_readdatavalid} !== {13'h021, 1'b1}) begin n_errors++; $display("FAIL rst_mid_beat2: got addr %h valid %b exp 021 1", mem_address, m0_readdatavalid); end
        reset_n = 1'b0;
        #1;
        n_checks++; if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, mem_chipselect} !== 4'b1100) begin n_errors++; $display("FAIL rst_mid_assert: got %b exp 1100", {m0_waitrequest, m1_waitrequest, m0_readdatavalid, mem_chipselect}); end
        for (int k = 0; k < 2; k++) begin
            idle();
            n_checks++; if ({m0_readdatavalid, mem_chipselect} !== 2'b00) begin n_errors++; $display("FAIL rst_mid_hold %0d: got %b exp 00", k, {m0_readdatavalid, mem_chipselect}); end
        end
        reset_n = 1'b1;
        idle();
        n_checks++; if ({m0_readdatavalid, mem_chipselect} !== 2'b00) begin n_errors++; $display("FAIL rst_mid_release: got %b exp 00", {m0_readdatavalid, mem_chipselect}); end
        drive(1'b1, 13'h030, 5'd3, 1'b0, 1'b0, 13'd0, 4'h0, 32'd0);
        n_checks++; if ({m0_waitrequest, mem_address} !== {1'b0, 13'h030}) begin n_errors++; $display("FAIL rst_mid_fresh: got w0 %b addr %h exp 0 030", m0_waitrequest, mem_address); end
        for (int k = 1; k <= 3; k++) begin
            idle();
            n_checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, ref_mem[48 + k - 1]}) begin n_errors++; $display("FAIL rst_mid_fresh_data %0d: got %b %h exp 1 %h", k, m0_readdatavalid, m0_readdata, ref_mem[48 + k - 1]); end
        end
        idle();
        n_checks++; if (m0_readdatavalid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_fresh_tail: got %b exp 0", m0_readdatavalid); end
    endtask

    function automatic logic [12:0] pick_addr();
        int sel;
        sel = $urandom_range(0, 2);
        if (sel == 0) return 13'($urandom_range(0, 31));
        else if (sel == 1) return 13'($urandom_range(5110, 5135));
        else return 13'($urandom_range(8180, 8191));
    endfunction

    // Transaction-level model: one RAM access per cycle, bursts own the port until done.
    task automatic test_random();
        logic        r0, r1, w1, g0, g1, acc, acc_w, exp_v0, exp_v1;
        logic [12:0] a0, a1, acc_a, b_addr;
        logic [4:0]  bc;
        logic [3:0]  be;
        logic [31:0] wd, exp_d;
        int          b_left, starve;
        exp_v0 = 1'b0; exp_v1 = 1'b0; exp_d = 32'd0; b_left = 0; b_addr = 13'd0; starve = 0;
        for (int c = 0; c < 600; c++) begin
            r0 = ($urandom_range(0, 99) < 40); a0 = pick_addr(); bc = 5'($urandom_range(0, 20));
            r1 = ($urandom_range(0, 99) < 45); w1 = ($urandom_range(0, 99) < 50); a1 = pick_addr();
            be = 4'($urandom_range(0, 15)); wd = $urandom;
            drive(r0, a0, bc, r1, w1, a1, be, wd);
            n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== {exp_v0, exp_v1}) begin n_errors++; $display("FAIL rand_valid c%0d: got %b%b exp %b%b", c, m0_readdatavalid, m1_readdatavalid, exp_v0, exp_v1); end
            if (exp_v0 || exp_v1) begin
                n_checks++; if ((exp_v1 ? m1_readdata : m0_readdata) !== exp_d) begin n_errors++; $display("FAIL rand_data c%0d: got %h exp %h", c, exp_v1 ? m1_readdata : m0_readdata, exp_d); end
            end
            g0 = 1'b0; g1 = 1'b0; acc = 1'b0; acc_w = 1'b0; acc_a = 13'd0;
            if (b_left > 0) begin
                acc = 1'b1; acc_a = b_addr; b_addr = b_addr + 13'd1; b_left--;
            end else if ((r1 || w1) && (!r0 || starve == 8)) begin
                g1 = 1'b1; acc = 1'b1; acc_a = a1; acc_w = w1;
            end else if (r0) begin
                g0 = 1'b1; acc = 1'b1; acc_a = a0; b_addr = a0 + 13'd1;
                b_left = ((bc == 5'd0) ? 1 : ((bc > 5'd16) ? 16 : int'(bc))) - 1;
            end
            n_checks++; if ({m0_waitrequest, m1_waitrequest} !== {~g0, ~g1}) begin n_errors++; $display("FAIL rand_wait c%0d: got %b%b exp %b%b", c, m0_waitrequest, m1_waitrequest, ~g0, ~g1); end
            n_checks++; if (mem_chipselect !== (acc && acc_a < 13'd5120)) begin n_errors++; $display("FAIL rand_cs c%0d: got %b exp %b", c, mem_chipselect, acc && acc_a < 13'd5120); end
            if (acc && acc_a < 13'd5120) begin
                n_checks++; if ({mem_address, mem_write} !== {acc_a, acc_w}) begin n_errors++; $display("FAIL rand_addr c%0d: got %h %b exp %h %b", c, mem_address, mem_write, acc_a, acc_w); end
            end
            exp_v0 = acc && !acc_w && !g1;
            exp_v1 = acc && !acc_w && g1;
            exp_d  = (acc_a < 13'd5120) ? ref_mem[acc_a] : 32'd0;
            if (acc_w && acc_a < 13'd5120) ref_mem[acc_a] = merge(ref_mem[acc_a], wd, be);
`ifdef VGA_ARB_STARVE_GUARD_EN
            if ((r1 || w1) && g1) starve = 0;
            else if ((r1 || w1) && starve < 8) starve++;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 5120; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_burst();
        test_write_read();
        test_contention();
        test_oob();
        test_starve();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
